// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI read port between fetch (port 0) and data (port 1).
// Optional one-entry hit cache enabled by defining FLASH_ARB_HIT_CACHE_EN.
module flash_read_arbiter #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_arvalid,
  output logic            s0_arready,
  input  logic [31:0]     s0_araddr,
  input  logic [ID_W-1:0] s0_arid,
  output logic            s0_rvalid,
  input  logic            s0_rready,
  output logic [31:0]     s0_rdata,
  output logic [ID_W-1:0] s0_rid,
  output logic [1:0]      s0_rresp,
  output logic            s0_rlast,
  input  logic            s1_arvalid,
  output logic            s1_arready,
  input  logic [31:0]     s1_araddr,
  input  logic [ID_W-1:0] s1_arid,
  output logic            s1_rvalid,
  input  logic            s1_rready,
  output logic [31:0]     s1_rdata,
  output logic [ID_W-1:0] s1_rid,
  output logic [1:0]      s1_rresp,
  output logic            s1_rlast,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [31:0]     m_araddr,
  output logic [ID_W-1:0] m_arid,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            cache_flush
);

  // state  | meaning
  // IDLE   | arbitrate, accept one upstream address
  // ADDR   | present aligned address downstream
  // WAIT_R | accept downstream read data
  // RESP   | return data to the granted requester
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]      state;
  logic            last;
  logic            grant;
  logic [29:0]     addr_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;

  logic            win;
  logic            hs;
  logic [29:0]     win_addr;
  logic [ID_W-1:0] win_id;
  logic            hit;
  logic [31:0]     hit_data;
  logic            unused_bits;

  always_comb begin
    if (s0_arvalid && s1_arvalid) win = ~last;
    else                          win = ~s0_arvalid;
    win_addr = win ? s1_araddr[31:2] : s0_araddr[31:2];
    win_id   = win ? s1_arid : s0_arid;
    // rst gate keeps arready low during reset even though the FSM sits in IDLE
    hs       = (state == IDLE) && (s0_arvalid || s1_arvalid) && !rst;
  end

  assign s0_arready = hs && !win;
  assign s1_arready = hs && win;

`ifdef FLASH_ARB_HIT_CACHE_EN
  logic        cvalid;
  logic [29:0] ctag;
  logic [31:0] cdata;

  assign hit      = cvalid && (ctag == win_addr);
  assign hit_data = cdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cvalid <= 1'b0;
      ctag   <= '0;
      cdata  <= '0;
    end else begin
      if (state == WAIT_R && m_rvalid) begin
        if (m_rresp == 2'b00) begin
          cvalid <= 1'b1;
          ctag   <= addr_q;
          cdata  <= m_rdata;
        end else begin
          cvalid <= 1'b0;
        end
      end
      if (cache_flush) cvalid <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign unused_bits = ^{cache_flush, s0_araddr[1:0], s1_araddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant   <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          grant  <= win;
          last   <= win;
          addr_q <= win_addr;
          id_q   <= win_id;
          if (hit) begin
            rdata_q <= hit_data;
            rresp_q <= 2'b00;
            state   <= RESP;
          end else begin
            state   <= ADDR;
          end
        end
        ADDR: if (m_arready) state <= WAIT_R;
        WAIT_R: if (m_rvalid) begin
          rdata_q <= m_rdata;
          rresp_q <= m_rresp;
          state   <= RESP;
        end
        RESP: if (grant ? s1_rready : s0_rready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_arvalid = (state == ADDR);
  assign m_araddr  = {addr_q, 2'b00};
  assign m_arid    = '0;
  assign m_rready  = (state == WAIT_R);

  assign s0_rvalid = (state == RESP) && !grant;
  assign s1_rvalid = (state == RESP) && grant;
  assign s0_rdata  = rdata_q;
  assign s1_rdata  = rdata_q;
  assign s0_rid    = id_q;
  assign s1_rid    = id_q;
  assign s0_rresp  = rresp_q;
  assign s1_rresp  = rresp_q;
  assign s0_rlast  = 1'b1;
  assign s1_rlast  = 1'b1;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: vector table, hand sequences and randomized traffic
// checked against a transaction-level model of arbitration and the optional hit cache.
module tb_flash_read_arbiter;
  localparam int ID_W = 4;
`ifdef FLASH_ARB_HIT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata;
  logic [ID_W-1:0] s0_arid, s1_arid, s0_rid, s1_rid, m_arid;
  logic [1:0] s0_rresp, s1_rresp, m_rresp;
  logic m_arvalid, m_arready, m_rvalid, m_rready, cache_flush;
  logic [31:0] m_araddr, m_rdata;

  int n_checks = 0;
  int n_fail = 0;

  // transaction-level model state
  bit          mdl_last;
  bit          mdl_cvalid;
  logic [29:0] mdl_ctag;
  logic [31:0] mdl_cdata;

  always #5 clk = ~clk;

  flash_read_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arid(s0_arid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rid(s0_rid),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arid(s1_arid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rid(s1_rid),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .cache_flush(cache_flush)
  );

  typedef struct {
    logic            v0, v1;
    logic [31:0]     a0, a1;
    logic [ID_W-1:0] i0, i1;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            exp_grant;
    logic [31:0]     exp_araddr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, {s0_arready, s1_arready}, 2'b00);
    check({tag, "_rvalid"}, {s0_rvalid, s1_rvalid}, 2'b00);
    check({tag, "_m_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_m_rready"}, m_rready, 1'b0);
    check({tag, "_rdata"}, {s0_rdata, s1_rdata}, 64'h0);
    check({tag, "_rid_rresp"}, {s0_rid, s1_rid, s0_rresp, s1_rresp}, 12'h0);
    check({tag, "_m_araddr"}, m_araddr, 32'h0);
    check({tag, "_rlast"}, {s0_rlast, s1_rlast}, 2'b11);
  endtask

  function automatic logic model_winner(input logic v0, input logic v1);
    return (v0 && v1) ? !mdl_last : v1;
  endfunction

  task automatic flush_cache();
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    mdl_cvalid = 1'b0;
  endtask

  // One full transaction; m_rvalid is driven with junk during ADDR to prove it is ignored.
  task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [ID_W-1:0] i0, input logic [ID_W-1:0] i1,
                         input int ar_lat, input int r_lat, input int rr_lat,
                         input logic [31:0] data, input logic [1:0] resp,
                         input logic exp_grant, input logic [31:0] exp_araddr, input bit hold_other);
    logic [ID_W-1:0] wid;
    bit hit;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    wid = exp_grant ? i1 : i0;
    hit = CACHE_ON && mdl_cvalid && (mdl_ctag == exp_araddr[31:2]);
    s0_arvalid = v0; s0_araddr = a0; s0_arid = i0;
    s1_arvalid = v1; s1_araddr = a1; s1_arid = i1;
    #1;
    check("arready_win", {s0_arready, s1_arready}, exp_grant ? 2'b01 : 2'b10);
    tick();
    s0_arvalid = hold_other && exp_grant;
    s1_arvalid = hold_other && !exp_grant;
    mdl_last = exp_grant;
    #1;
    check("arready_busy", {s0_arready, s1_arready}, 2'b00);
    if (hit) begin
      check("hit_no_m_arvalid", m_arvalid, 1'b0);
      exp_data = mdl_cdata;
      exp_resp = 2'b00;
    end else begin
      exp_data = data;
      exp_resp = resp;
      for (int k = 0; k < ar_lat; k++) begin
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0; m_rresp = 2'b11;
        #1;
        check("m_arvalid_hold", m_arvalid, 1'b1);
        check("m_araddr_hold", m_araddr, exp_araddr);
        check("m_rready_in_addr", m_rready, 1'b0);
        check("arready_busy_addr", {s0_arready, s1_arready}, 2'b00);
        tick();
      end
      m_rvalid = 1'b0;
      m_arready = 1'b1;
      #1;
      check("m_arvalid", m_arvalid, 1'b1);
      check("m_araddr", m_araddr, exp_araddr);
      check("m_arid", m_arid, '0);
      tick();
      m_arready = 1'b0;
      for (int k = 0; k < r_lat; k++) begin
        #1;
        check("m_rready_wait", m_rready, 1'b1);
        check("m_arvalid_wait", m_arvalid, 1'b0);
        check("arready_busy_wait", {s0_arready, s1_arready}, 2'b00);
        tick();
      end
      m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
      #1;
      check("m_rready", m_rready, 1'b1);
      tick();
      m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
      if (resp == 2'b00) begin
        mdl_cvalid = 1'b1; mdl_ctag = exp_araddr[31:2]; mdl_cdata = data;
      end else begin
        mdl_cvalid = 1'b0;
      end
    end
    for (int k = 0; k <= rr_lat; k++) begin
      s0_rready = exp_grant ? 1'b1 : (k == rr_lat);
      s1_rready = exp_grant ? (k == rr_lat) : 1'b1;
      #1;
      check("rvalid_route", {s0_rvalid, s1_rvalid}, exp_grant ? 2'b01 : 2'b10);
      check("rdata", exp_grant ? s1_rdata : s0_rdata, exp_data);
      check("rid", exp_grant ? s1_rid : s0_rid, wid);
      check("rresp", exp_grant ? s1_rresp : s0_rresp, exp_resp);
      check("rlast", exp_grant ? s1_rlast : s0_rlast, 1'b1);
      check("arready_busy_resp", {s0_arready, s1_arready}, 2'b00);
      tick();
    end
    s0_rready = 1'b0;
    s1_rready = 1'b0;
    #1;
    check("rvalid_done", {s0_rvalid, s1_rvalid}, 2'b00);
    if (hold_other) check("pending_served", {s0_arready, s1_arready}, exp_grant ? 2'b10 : 2'b01);
  endtask

  vec_t tbl[7];

  initial begin
    logic v0, v1, g;
    logic [31:0] a0, a1;
    logic [31:0] pool[4];

    rst = 1'b1;
    s0_arvalid = 0; s0_araddr = 0; s0_arid = 0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = 0; s1_arid = 0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; cache_flush = 0;
    mdl_last = 1'b1; mdl_cvalid = 1'b0; mdl_ctag = '0; mdl_cdata = '0;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_1006, 32'h0,         4'h5, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_1004};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_3003, 4'h1, 4'h9, 32'h1234_5678, 2'b00, 1'b1, 32'h0000_3000};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0000_9000, 4'h2, 4'hA, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_2004};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_2008, 32'h0000_3010, 4'h3, 4'hB, 32'h0BAD_CAFE, 2'b10, 1'b1, 32'h0000_3010};
    tbl[4] = '{1'b0, 1'b1, 32'h0,         32'h0000_400B, 4'h0, 4'hC, 32'h5555_AAAA, 2'b00, 1'b1, 32'h0000_4008};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000, 4'h7, 4'hD, 32'hA5A5_5A5A, 2'b00, 1'b0, 32'h0000_5000};
    tbl[6] = '{1'b0, 1'b1, 32'h0,         32'h0000_7001, 4'h0, 4'hE, 32'h0F0F_F0F0, 2'b01, 1'b1, 32'h0000_7000};
    pool = '{32'h0000_0100, 32'h0000_0104, 32'h0000_2000, 32'hFFFF_FFF0};

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].i0, tbl[i].i1, i % 3, (i + 1) % 3, i % 2,
              tbl[i].data, tbl[i].resp, tbl[i].exp_grant, tbl[i].exp_araddr, 1'b0);

    // port 1 waits while port 0 is in flight, then gets served
    run_txn(1'b1, 1'b0, 32'h0000_8000, 32'h0000_8800, 4'h4, 4'h6, 1, 2, 1, 32'h1111_2222, 2'b00,
            1'b0, 32'h0000_8000, 1'b1);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_8800, 4'h0, 4'h6, 0, 0, 0, 32'h3333_4444, 2'b00,
            1'b1, 32'h0000_8800, 1'b0);

    // cache sequence: repeat read, flush, error response invalidation
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h1, 4'h0, 0, 1, 0, 32'h1111_1111, 2'b00, 1'b0, 32'h100, 1'b0);
    run_txn(1'b1, 1'b0, 32'h102, 32'h0, 4'h2, 4'h0, 0, 1, 0, 32'h9999_9999, 2'b00, 1'b0, 32'h100, 1'b0);
    flush_cache();
    run_txn(1'b0, 1'b1, 32'h0, 32'h100, 4'h0, 4'h3, 0, 0, 0, 32'h2222_2222, 2'b00, 1'b1, 32'h100, 1'b0);
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 4'h4, 4'h0, 1, 0, 0, 32'h3333_3333, 2'b10, 1'b0, 32'h200, 1'b0);
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 4'h5, 4'h0, 0, 0, 0, 32'h4444_4444, 2'b00, 1'b0, 32'h200, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int p;
      p = $urandom_range(1, 3);
      v0 = p[0];
      v1 = p[1];
      a0 = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      a1 = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      g = model_winner(v0, v1);
      if ($urandom_range(0, 5) == 0) flush_cache();
      run_txn(v0, v1, a0, a1, 4'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom, ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00,
              g, (g ? a1 : a0) & 32'hFFFF_FFFC, 1'b0);
    end

    // reset in the middle of WAIT_R
    s0_arvalid = 1'b1; s0_araddr = 32'h0000_A000; s0_arid = 4'h3;
    s1_arvalid = 1'b0;
    #1;
    check("mid_arready", s0_arready, 1'b1);
    tick();
    s0_arvalid = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    #1;
    check("mid_wait_r", m_rready, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    mdl_last = 1'b1;
    mdl_cvalid = 1'b0;
    tick();
    run_txn(1'b1, 1'b1, 32'h0000_B000, 32'h0000_C000, 4'h8, 4'h9, 0, 0, 0, 32'h7777_8888, 2'b00,
            1'b0, 32'h0000_B000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
